// File: rtl/bp_ptw_fill.sv
// Sv39 hardware page-table walker refilling the TLB from one miss at a time.
// Optional feature macro: BP_PTW_GIGAPAGE_EN (level-2 leaves fill as gigapages instead of splintering).
module bp_ptw_fill #(
  parameter int paddr_width_p      = 56,
  parameter int vtag_width_p       = 27,
  parameter int ptag_width_p       = 44,
  parameter int pte_width_p        = 64,
  parameter int page_table_depth_p = 3,
  parameter int page_idx_width_p   = 9,
  localparam int entry_width_lp    = ptag_width_p + 7
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [ptag_width_p-1:0]   base_ppn_i,
  input  logic                      miss_v_i,
  input  logic [vtag_width_p-1:0]   miss_vtag_i,
  output logic                      ready_o,
  output logic                      busy_o,
  output logic                      mem_req_v_o,
  output logic [paddr_width_p-1:0]  mem_req_addr_o,
  input  logic                      mem_req_ready_i,
  input  logic                      mem_resp_v_i,
  input  logic [pte_width_p-1:0]    mem_resp_data_i,
  output logic                      tlb_w_v_o,
  output logic [vtag_width_p-1:0]   tlb_w_vtag_o,
  output logic [entry_width_lp-1:0] tlb_w_entry_o,
  output logic                      fault_v_o,
  output logic [vtag_width_p-1:0]   fault_vtag_o
);

  localparam int lvl_w_lp = $clog2(page_table_depth_p);
  localparam int addr_full_w_lp = ptag_width_p + page_idx_width_p + 3;
  localparam logic [lvl_w_lp-1:0] top_level_lp = lvl_w_lp'(page_table_depth_p - 1);
  localparam logic [ptag_width_p-1:0] ones_lp = {ptag_width_p{1'b1}};

  typedef enum logic [2:0] {
    e_idle  = 3'd0,
    e_send  = 3'd1,
    e_wait  = 3'd2,
    e_drain = 3'd3,
    e_fill  = 3'd4,
    e_fault = 3'd5
  } state_e;

  state_e state_r, state_n_s;

  logic [vtag_width_p-1:0]   vtag_r;
  logic [ptag_width_p-1:0]   ppn_r;
  logic [lvl_w_lp-1:0]       level_r;
  logic [entry_width_lp-1:0] entry_r;

  logic [31:0]                shamt_s;
  logic [page_idx_width_p-1:0] vpn_s;
  logic [addr_full_w_lp-1:0]  addr_full_s;
  logic [ptag_width_p-1:0]    low_mask_s;

  logic [ptag_width_p-1:0]    pte_ppn_s;
  logic pte_v_s, pte_r_s, pte_w_s, pte_x_s, pte_u_s, pte_a_s, pte_d_s;
  logic pte_leaf_s, pte_misaligned_s, pte_fault_s, gigapage_s;
  logic [ptag_width_p-1:0]    leaf_ptag_s;
  logic [entry_width_lp-1:0]  entry_s;
  logic accept_s, walk_resp_s;
  logic unused_pte_bits_s;

  // Raw Sv39 PTE fields; G, RSW and the reserved top bits play no part in the fill
  assign pte_v_s   = mem_resp_data_i[0];
  assign pte_r_s   = mem_resp_data_i[1];
  assign pte_w_s   = mem_resp_data_i[2];
  assign pte_x_s   = mem_resp_data_i[3];
  assign pte_u_s   = mem_resp_data_i[4];
  assign pte_a_s   = mem_resp_data_i[6];
  assign pte_d_s   = mem_resp_data_i[7];
  assign pte_ppn_s = mem_resp_data_i[10 +: ptag_width_p];
  assign unused_pte_bits_s = ^{mem_resp_data_i[pte_width_p-1:ptag_width_p+10],
                               mem_resp_data_i[9:8], mem_resp_data_i[5]};

  // Bits below the current level's page boundary: VPN slices for the request, PPN slices for superpages
  assign shamt_s     = 32'(level_r) * 32'(page_idx_width_p);
  assign vpn_s       = page_idx_width_p'(vtag_r >> shamt_s);
  assign addr_full_s = {ppn_r, vpn_s, 3'b000};
  assign low_mask_s  = ~(ones_lp << shamt_s);

  assign pte_leaf_s       = pte_r_s | pte_x_s;
  assign pte_misaligned_s = pte_leaf_s & (|(pte_ppn_s & low_mask_s));
  assign pte_fault_s      = ~pte_v_s
                          | (~pte_r_s & pte_w_s)
                          | (~pte_leaf_s & (level_r == {lvl_w_lp{1'b0}}))
                          | pte_misaligned_s;

`ifdef BP_PTW_GIGAPAGE_EN
  assign gigapage_s = (level_r == top_level_lp);
`else
  assign gigapage_s = 1'b0;
`endif

  assign leaf_ptag_s = (pte_ppn_s & ~low_mask_s) | (ptag_width_p'(vtag_r) & low_mask_s);
  assign entry_s     = {leaf_ptag_s, gigapage_s, pte_a_s, pte_d_s, pte_u_s,
                        pte_x_s, pte_w_s, pte_r_s};

  assign accept_s    = (state_r == e_idle) & miss_v_i & ~flush_i;
  assign walk_resp_s = (state_r == e_wait) & mem_resp_v_i & ~flush_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic; a flush with a request already in flight must wait out its response
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      e_idle: begin
        if (accept_s) state_n_s = e_send;
        else          state_n_s = e_idle;
      end
      e_send: begin
        if (mem_req_ready_i) state_n_s = flush_i ? e_drain : e_wait;
        else if (flush_i)    state_n_s = e_idle;
        else                 state_n_s = e_send;
      end
      e_wait: begin
        if (flush_i)           state_n_s = mem_resp_v_i ? e_idle : e_drain;
        else if (!mem_resp_v_i) state_n_s = e_wait;
        else if (pte_fault_s)   state_n_s = e_fault;
        else if (pte_leaf_s)    state_n_s = e_fill;
        else                    state_n_s = e_send;
      end
      e_drain: begin
        if (mem_resp_v_i) state_n_s = e_idle;
        else              state_n_s = e_drain;
      end
      e_fill:  state_n_s = e_idle;
      e_fault: state_n_s = e_idle;
      default: state_n_s = e_idle;
    endcase
  end

  // Walk context: captured at accept, descended on each non-leaf PTE, entry built on a leaf
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vtag_r  <= {vtag_width_p{1'b0}};
      ppn_r   <= {ptag_width_p{1'b0}};
      level_r <= {lvl_w_lp{1'b0}};
      entry_r <= {entry_width_lp{1'b0}};
    end else if (accept_s) begin
      vtag_r  <= miss_vtag_i;
      ppn_r   <= base_ppn_i;
      level_r <= top_level_lp;
    end else if (walk_resp_s && !pte_fault_s) begin
      if (pte_leaf_s) begin
        entry_r <= entry_s;
      end else begin
        ppn_r   <= pte_ppn_s;
        level_r <= level_r - lvl_w_lp'(1);
      end
    end
  end

  // Output decode from state; flush squashes a fill or fault in the same cycle
  always_comb begin
    ready_o        = 1'b0;
    busy_o         = 1'b0;
    mem_req_v_o    = 1'b0;
    tlb_w_v_o      = 1'b0;
    fault_v_o      = 1'b0;
    mem_req_addr_o = {paddr_width_p{1'b0}};
    tlb_w_vtag_o   = {vtag_width_p{1'b0}};
    tlb_w_entry_o  = {entry_width_lp{1'b0}};
    fault_vtag_o   = {vtag_width_p{1'b0}};
    if (!reset_i) begin
      ready_o        = (state_r == e_idle);
      busy_o         = (state_r != e_idle);
      mem_req_v_o    = (state_r == e_send);
      tlb_w_v_o      = (state_r == e_fill) & ~flush_i;
      fault_v_o      = (state_r == e_fault) & ~flush_i;
      mem_req_addr_o = paddr_width_p'(addr_full_s);
      tlb_w_vtag_o   = vtag_r;
      tlb_w_entry_o  = entry_r;
      fault_vtag_o   = vtag_r;
    end else begin
      ready_o = 1'b0;
    end
  end

endmodule

// File: doc/bp_ptw_fill.md
# bp_ptw_fill

Hardware page-table walker that refills the core TLB. Accepts one miss (virtual tag) at a time and walks the Sv39 table rooted at the satp PPN, issuing 8-byte PTE reads over a valid/ready memory port. Delivers either a single-cycle TLB write (vtag plus `bp_pte_leaf_s` entry) or a page-fault pulse. Sits between the MMU miss logic and the D$/memory request path, and drives the TLB's write-side `v_i`/`w_i`/`vtag_i`/`entry_i`.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: supplies `vaddr_width_p`, `paddr_width_p`, `vtag_width_p` (27), `ptag_width_p`.
- `pte_width_p`, default `sv39_pte_width_gp` (64): PTE width.
- `page_table_depth_p`, default `sv39_levels_gp` (3): walk levels.
- `page_idx_width_p`, default `sv39_page_idx_width_gp` (9): VPN slice width.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  aborts any walk; no fill or fault is produced.
- `base_ppn_i`  in  `ptag_width_p`  root table PPN; sampled at miss accept.
- `miss_v_i`  in  1  miss request valid.
- `miss_vtag_i`  in  `vtag_width_p`  missing virtual tag.
- `ready_o`  out  1  walker idle; a miss is accepted when `miss_v_i & ready_o`.
- `busy_o`  out  1  equals `~ready_o` outside reset.
- `mem_req_v_o`  out  1  PTE read valid.
- `mem_req_addr_o`  out  `paddr_width_p`  PTE physical address.
- `mem_req_ready_i`  in  1  memory accepts the request.
- `mem_resp_v_i`  in  1  PTE data valid.
- `mem_resp_data_i`  in  `pte_width_p`  raw Sv39 PTE.
- `tlb_w_v_o`  out  1  one-cycle TLB fill strobe.
- `tlb_w_vtag_o`  out  `vtag_width_p`  fill tag.
- `tlb_w_entry_o`  out  `bp_pte_leaf_width(paddr_width_p)`  leaf entry.
- `fault_v_o`  out  1  one-cycle page-fault pulse.
- `fault_vtag_o`  out  `vtag_width_p`  faulting tag.

## Operation
- States: `e_idle`, `e_send`, `e_wait`, `e_drain`, `e_fill`, `e_fault`.
- `e_idle`: `ready_o=1`. On accept, latch the vtag and `base_ppn_i`, set level=2, go to `e_send`.
- `e_send`: `mem_req_v_o=1` with address `{ppn_r, vpn[level], 3'b000}` truncated to `paddr_width_p`. On `mem_req_ready_i`, go to `e_wait`. The request is held stable until accepted.
- `e_wait`: on `mem_resp_v_i`, decode:
  - Fault if `V=0`, or `R=0 & W=1`, or non-leaf (`R=0 & X=0`) at level 0, or a superpage with nonzero low PPN slices (level 2: PPN[17:0]; level 1: PPN[8:0]). Go to `e_fault`.
  - Non-leaf: `ppn_r <= pte.ppn`, level−1, go to `e_send`.
  - Leaf: build the entry, go to `e_fill`.
- Leaf construction: `ptag` = PTE PPN with superpage low slices replaced by the matching vtag slices.
  - Level 1 (2 MiB) leaf always splinters to a 4 KiB entry, `gigapage=0`.
  - Level 2 behaviour is set by Configuration.
  - Copy `a`, `d`, `u`, `x`, `w`, `r` from the PTE.
- `e_fill`: `tlb_w_v_o=1` for exactly one cycle, then `e_idle`.
- `e_fault`: `fault_v_o=1` for exactly one cycle, then `e_idle`.
- `flush_i`:
  - In `e_send` before handshake, or in `e_idle`/`e_fill`/`e_fault`: next state `e_idle`. Any `tlb_w_v_o`/`fault_v_o` asserted that cycle is suppressed.
  - In `e_wait`: go to `e_drain`, which discards the outstanding response and then returns to `e_idle`.
  - Flush coincident with a send handshake also goes to `e_drain`.
- `miss_v_i` is ignored when `ready_o=0`.

## Timing
- During and one cycle after `reset_i`: state `e_idle`. While `reset_i` is high, `ready_o=0`. All valid outputs (`mem_req_v_o`, `tlb_w_v_o`, `fault_v_o`) are 0 during reset. Data outputs are 0 at reset.
- Accept in cycle N: `mem_req_v_o` asserts in N+1. Each level costs 1 cycle (send) plus response latency.
- With ready held high and a 1-cycle response, a level-0 fill takes accept N, requests N+1/N+3/N+5, and `tlb_w_v_o` at N+7. `ready_o` returns at N+8.
- At most one outstanding request. Responses arriving outside `e_wait`/`e_drain` are a protocol error and ignored.
- Output registers: `tlb_w_*` and `fault_*` come from state registers, not from `mem_resp_*` combinationally.

## Configuration
- `BP_PTW_GIGAPAGE_EN` defined: a valid level-2 leaf fills with `gigapage=1` and `ptag` = {PPN[43:18], vtag[17:0]} as given by the PTE (low bits don't-care for TLB).
- Undefined: a level-2 leaf splinters to a 4 KiB entry, `gigapage=0`, with `ptag` low 18 bits taken from vtag[17:0]. Use this for builds with `els_1g_p=0`.

## Test plan
- 4 KiB walk: root ppn 0x80000, vtag 0x0012345; PTEs non-leaf→non-leaf→leaf ppn 0x81234 RWXAD → addrs 0x80000000+8·vpn2, …; fill ptag 0x81234, `gigapage=0`, `tlb_w_v_o` one cycle.
- Megapage: level-1 leaf PPN 0x80200 → ptag 0x80200 | vtag[8:0], `gigapage=0`.
- Gigapage: level-2 leaf PPN 0x40000 → with macro `gigapage=1`; without macro ptag = 0x40000 | vtag[17:0], `gigapage=0`.
- Faults: `V=0` at level 2; `W=1,R=0`; misaligned 2 MiB (PPN[0]=1) → `fault_v_o` one cycle, `fault_vtag_o` = vtag, no TLB write.
- Backpressure: hold `mem_req_ready_i=0` 5 cycles → address stable, single request issued.
- Flush in `e_wait`: response arrives 3 cycles later → dropped, no fill/fault, `ready_o` high the cycle after the response.
